// File: rtl/piso_serializer_ctrl.sv
// piso_serializer_ctrl: framed serial transmitter (start, data, [parity], stop)
// built around a parallel-in/serial-out shift register.
// Optional even-parity bit is enabled by defining PIPO_PARITY_EN.
module piso_serializer_ctrl #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_serial,
    output logic             o_busy,
    output logic             o_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(WIDTH - 1);

`ifdef PIPO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_n;
    logic [BAUD_W-1:0]  baud, baud_n;
    logic [BIT_W-1:0]   bitcnt, bitcnt_n;
    logic [WIDTH-1:0]   sr, sr_n;
    logic               serial_n;
    logic               wrap;
`ifdef PIPO_PARITY_EN
    logic               par, par_n;
`endif

    assign wrap    = (baud == BAUD_MAX);
    assign o_ready = (state == IDLE);

    // Next-state, counter, shift and line-level logic; o_serial is derived
    // from the next state so the registered line lines up with the state.
    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        sr_n     = sr;
`ifdef PIPO_PARITY_EN
        par_n    = par;
`endif
        // Baud counter free-runs through the whole frame, wrapping per bit
        if (state != IDLE) begin
            baud_n = wrap ? '0 : baud + 1'b1;
        end
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_n  = START;
                    baud_n   = '0;
                    bitcnt_n = '0;
                    sr_n     = i_data;
`ifdef PIPO_PARITY_EN
                    par_n    = ^i_data;
`endif
                end
            end
            START: begin
                if (wrap) state_n = DATA;
            end
            DATA: begin
                if (wrap) begin
                    // Vacated positions fill with zero
                    if (LSB_FIRST != 0) sr_n = {1'b0, sr[WIDTH-1:1]};
                    else                sr_n = {sr[WIDTH-2:0], 1'b0};
                    if (bitcnt == BIT_MAX) begin
                        bitcnt_n = '0;
`ifdef PIPO_PARITY_EN
                        state_n  = PARITY;
`else
                        state_n  = STOP;
`endif
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
`ifdef PIPO_PARITY_EN
            PARITY: begin
                if (wrap) state_n = STOP;
            end
`endif
            STOP: begin
                if (wrap) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        serial_n = 1'b1;
        case (state_n)
            START:  serial_n = 1'b0;
            DATA:   serial_n = (LSB_FIRST != 0) ? sr_n[0] : sr_n[WIDTH-1];
`ifdef PIPO_PARITY_EN
            PARITY: serial_n = par_n;
`endif
            default: serial_n = 1'b1;
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bitcnt   <= '0;
            sr       <= '0;
`ifdef PIPO_PARITY_EN
            par      <= 1'b0;
`endif
            o_serial <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bitcnt   <= bitcnt_n;
            sr       <= sr_n;
`ifdef PIPO_PARITY_EN
            par      <= par_n;
`endif
            o_serial <= serial_n;
            o_busy   <= (state_n != IDLE);
            o_done   <= (state == STOP) && (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: two instances (LSB-first/4 clk per bit and
// MSB-first/1 clk per bit); expected line bits are queued at handshake and
// popped as the line is observed. Inputs driven and outputs sampled on negedge.
module tb_piso_serializer_ctrl;
`ifdef PIPO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, a_serial, a_busy, a_done;
    logic       b_ready, b_serial, b_busy, b_done;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    piso_serializer_ctrl #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .o_serial(a_serial), .o_busy(a_busy), .o_done(a_done)
    );

    piso_serializer_ctrl #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .o_serial(b_serial), .o_busy(b_busy), .o_done(b_done)
    );

    function automatic logic get_ser(input int s);
        return (s != 0) ? b_serial : a_serial;
    endfunction
    function automatic logic get_busy(input int s);
        return (s != 0) ? b_busy : a_busy;
    endfunction
    function automatic logic get_rdy(input int s);
        return (s != 0) ? b_ready : a_ready;
    endfunction
    function automatic logic get_done(input int s);
        return (s != 0) ? b_done : a_done;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference frame: start, 8 data bits in transmit order, [even parity], stop
    task automatic push_frame(input logic [7:0] d, input bit lsb);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb ? d[i] : d[7-i]);
`ifdef PIPO_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    task automatic check_idle(input string tag, input int s, input logic done_exp);
        check({tag, ".ser"},  get_ser(s),  1'b1);
        check({tag, ".busy"}, get_busy(s), 1'b0);
        check({tag, ".rdy"},  get_rdy(s),  1'b1);
        check({tag, ".done"}, get_done(s), done_exp);
    endtask

    // Observe one frame cycle by cycle starting at cycle E0+1. abort_at >= 0
    // pulses rst in the second cycle of that bit index. poke drives a busy-time
    // valid with 0xFF on instance A. Ends at the o_done cycle (or after abort).
    task automatic play(input int s, input int cpb, input int abort_at, input bit poke);
        logic b;
        for (int k = 0; k < NB; k++) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1'b1, 1'b0);
                return;
            end
            b = exp_q.pop_front();
            for (int c = 0; c < cpb; c++) begin
                if (k == abort_at && c == 1) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_idle("abort", s, 1'b0);
                    exp_q.delete();
                    return;
                end
                check($sformatf("bit%0d.c%0d", k, c), get_ser(s), b);
                check("frame.busy", get_busy(s), 1'b1);
                check("frame.rdy",  get_rdy(s),  1'b0);
                check("frame.done", get_done(s), 1'b0);
                if (poke) begin
                    a_valid = 1'b1;
                    a_data  = 8'hFF ^ 8'(k + c);
                end
                @(negedge clk);
            end
        end
        check_idle("done_cycle", s, 1'b1);
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        check_idle("rst_a", 0, 1'b0);
        check_idle("rst_b", 1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 0xA5 on A, then one cycle after done the pulse must be gone
        a_valid = 1'b1; a_data = 8'hA5; push_frame(8'hA5, 1'b1);
        @(negedge clk);
        a_valid = 1'b0; a_data = 8'h00;
        play(0, 4, -1, 1'b0);
        @(negedge clk);
        check_idle("after_a5", 0, 1'b0);

        // Frame 0x07 (parity 1 when enabled)
        a_valid = 1'b1; a_data = 8'h07; push_frame(8'h07, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        play(0, 4, -1, 1'b0);
        @(negedge clk);

        // Busy-time valid and changing i_data must not affect frame 0x3C
        a_valid = 1'b1; a_data = 8'h3C; push_frame(8'h3C, 1'b1);
        @(negedge clk);
        play(0, 4, -1, 1'b1);
        a_valid = 1'b0;
        @(negedge clk);
        check_idle("no_extra_frame", 0, 1'b0);
        @(negedge clk);
        check_idle("no_extra_frame2", 0, 1'b0);

        // Reset during data bit 3 (line index 4), then a clean 0x5A frame
        a_valid = 1'b1; a_data = 8'hA5; push_frame(8'hA5, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        play(0, 4, 4, 1'b0);
        @(negedge clk);
        check_idle("post_abort", 0, 1'b0);
        a_valid = 1'b1; a_data = 8'h5A; push_frame(8'h5A, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        play(0, 4, -1, 1'b0);
        @(negedge clk);

        // B: back-to-back 0x81 then 0x3C, valid held high; second handshake
        // lands in the done cycle, leaving exactly one idle-high cycle
        b_valid = 1'b1; b_data = 8'h81; push_frame(8'h81, 1'b0);
        @(negedge clk);
        b_data = 8'h3C; push_frame(8'h3C, 1'b0);
        play(1, 1, -1, 1'b0);
        @(negedge clk);
        b_valid = 1'b0;
        play(1, 1, -1, 1'b0);
        @(negedge clk);
        check_idle("b_end", 1, 1'b0);
        check("queue_empty", exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer_ctrl.md
Name: piso_serializer_ctrl

Overview:
Framed serial transmitter controller built around a parallel-in/serial-out shift register.
- Accepts one WIDTH-bit word per valid/ready handshake and captures it into an internal shift register.
- Sequences the word onto a single line as start bit, data bits, optional parity bit, then stop bit, each bit held for CLKS_PER_BIT clocks.
- Sits between a parallel word producer (FIFO or register file) and an off-block serial line.

Parameters:
WIDTH, 8, data bits per frame (>= 2)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>= 1)
LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
i_data  input  WIDTH  parallel word; sampled only on handshake
i_valid  input  1  producer has a word on i_data
o_ready  output  1  controller can accept a word (high only in IDLE)
o_serial  output  1  serial line, registered; idles high
o_busy  output  1  frame in progress (state != IDLE), registered
o_done  output  1  one-cycle pulse: frame fully transmitted

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, o_serial=1, o_busy=0, o_done=0, o_ready=1.
  - Shift register, bit counter and baud counter are cleared.
  - Reset mid-frame aborts the frame: line returns high on the next cycle, no o_done pulse, and the word is discarded.
- Handshake:
  - Transfer occurs at the edge where i_valid=1 and o_ready=1; i_data is captured at that edge.
  - i_data and i_valid are ignored while o_ready=0; no queuing.
  - i_data changes after capture have no effect.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY or STOP after WIDTH bits.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Line levels: START drives o_serial=0. DATA drives the current shift-register bit (bit 0 or bit WIDTH-1 per LSB_FIRST). STOP drives o_serial=1.
- Timing (handshake at edge E0):
  - o_serial goes low in the cycle after E0.
  - Bit k occupies cycles E0+1+k*CLKS_PER_BIT .. E0+(k+1)*CLKS_PER_BIT.
  - Total frame length is (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with parity.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; a bit advance occurs on wrap.
  - Bit counter counts 0..WIDTH-1 in DATA.
  - Counter widths use $clog2 with a minimum of 1 bit.
  - CLKS_PER_BIT=1 yields one bit per clock with no idle cycles inside the frame.
- Shift register shifts by one position on each data-bit advance; vacated bits fill with 0.
- Completion:
  - o_done=1 for exactly one cycle, the first cycle back in IDLE, coincident with o_ready returning to 1 and o_busy to 0.
  - A new handshake in that same cycle is legal, so frames are separated by exactly one idle-high cycle.
- o_busy is high from the cycle after E0 through the last STOP cycle.

Optional Feature:
Macro PIPO_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. It transmits even parity, the XOR of all WIDTH captured data bits, computed at capture. Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=4, LSB_FIRST=1, send 0xA5 without parity -> o_serial sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_done in cycle E0+41; o_busy high for 40 cycles.
2. Same setup with PIPO_PARITY_EN defined, send 0xA5 -> parity bit 0 after the data bits; send 0x07 -> parity bit 1; frame 44 cycles; o_done at E0+45.
3. LSB_FIRST=0, CLKS_PER_BIT=1, send 0x81 then hold i_valid high with 0x3C -> bits 0,1,0,0,0,0,0,0,1,1, then exactly one idle-high cycle, then frame 0x3C. The second handshake occurs in the o_done cycle.
4. Assert i_valid with 0xFF while busy, and change i_data mid-frame -> no extra frame, o_ready stays 0, and the transmitted bits match the originally captured word.
5. rst pulsed during DATA bit 3 of 0xA5 -> next cycle o_serial=1, o_busy=0, o_ready=1, no o_done; the following frame (0x5A) transmits correctly from its start bit.
